link_tx_serializer: RTL and testbench

//  Output-link stage fed directly by the 7:1 crossbar output mux (its registered out/send pair).

---
 rtl/md_noc_pkg.sv | 25 ++
 rtl/link_tx_serializer_if.sv | 50 +++++
 rtl/link_tx_serializer_pkt_fifo.sv | 81 ++++++++
 rtl/link_tx_serializer.sv | 222 ++++++++++++++++++++++
 tb/tb_link_tx_serializer.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_noc_pkg.sv
// ============================================================================
// Module      : md_noc_pkg
// Description : Shared constants and types for the inter-node link transmit
//               path. Packet/flit widths, flits per packet, valid-bit
//               position and the serialiser state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_noc_pkg;

    localparam int DATA_W    = 256;                 // packet width
    localparam int FLIT_W    = 64;                  // link flit width
    localparam int NF        = DATA_W / FLIT_W;     // flits per packet (>= 2)
    localparam int VALID_BIT = DATA_W - 1;          // packet valid flag position
    localparam int IDX_W     = (NF > 1) ? $clog2(NF) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

endpackage : md_noc_pkg

`default_nettype wire

// File: rtl/link_tx_serializer_if.sv
// ============================================================================
// Module      : link_tx_serializer_if
// Description : Bundle between the crossbar output mux / link receiver and the
//               transmit serialiser.
//   in_pkt     : packet from the crossbar mux (MSB = valid)
//   stall      : back-pressure to the mux-feeding routers
//   link_data  : flit payload
//   link_valid : flit valid
//   link_head  : first flit of a packet
//   link_tail  : last flit of a packet
//   credit_ret : receiver freed one packet slot (one-cycle pulse)
//   master modport = mux/receiver side, slave modport = serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface link_tx_serializer_if;
    import md_noc_pkg::*;

    logic [DATA_W-1:0] in_pkt;
    logic              stall;
    logic [FLIT_W-1:0] link_data;
    logic              link_valid;
    logic              link_head;
    logic              link_tail;
    logic              credit_ret;

    modport master (
        output in_pkt,
        output credit_ret,
        input  stall,
        input  link_data,
        input  link_valid,
        input  link_head,
        input  link_tail
    );

    modport slave (
        input  in_pkt,
        input  credit_ret,
        output stall,
        output link_data,
        output link_valid,
        output link_head,
        output link_tail
    );

endinterface : link_tx_serializer_if

`default_nettype wire

// File: rtl/link_tx_serializer_pkt_fifo.sv
// ============================================================================
// Module      : pkt_fifo
// Description : Packet-wide synchronous FIFO, asynchronous active-low reset.
//               A push while full is accepted only when a pop happens in the
//               same cycle (the pop frees the slot). Read data is the head
//               entry, available combinationally.
//   clk, rst_n : clock, async active-low reset
//   i_push     : write request (i_data)
//   i_pop      : read request (ignored when empty)
//   o_data     : head entry
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
//   o_count    : occupancy
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_fifo #(
    parameter int DEPTH = 8,                       // power of 2
    parameter int WIDTH = 256,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : pkt_fifo

`default_nettype wire

// File: rtl/link_tx_serializer.sv
// ============================================================================
// Module      : link_tx_serializer
// Description : Output-link stage behind the crossbar output mux. Buffers whole
//               packets, then serialises them MSB-flit first onto the link,
//               gated by receiver credits. Raises stall while the remaining
//               free entries only cover the packets already in flight
//               upstream.
//   clk            : clock
//   rst_n          : asynchronous active-low reset
//   bus (slave)    : in_pkt/stall from the mux, link_* flits, credit_ret
//   o_err_overflow : sticky, valid packet dropped because the buffer was full
//   o_err_credit   : sticky, credit returned while the counter was at maximum
//   o_pkt_count    : tail flits sent (only with LINK_STATS_EN)
//   o_stall_cycles : cycles with stall high (only with LINK_STATS_EN)
// Configuration : define LINK_STATS_EN to add the two statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_tx_serializer
    import md_noc_pkg::*;
#(
    parameter int PKT_FIFO_DEPTH = 8,
    parameter int CREDITS        = 4,
    parameter int STALL_SLACK    = 3
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    link_tx_serializer_if.slave bus,
    output logic                o_err_overflow,
    output logic                o_err_credit
`ifdef LINK_STATS_EN
   ,output logic [31:0]         o_pkt_count
   ,output logic [31:0]         o_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(PKT_FIFO_DEPTH + 1);
    localparam int CRD_W = $clog2(CREDITS + 1);

    // ------------------------------------------------------------------
    // Packet buffer
    // ------------------------------------------------------------------
    logic              w_in_valid;
    logic              w_pop;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_stall;

    assign w_in_valid = bus.in_pkt[VALID_BIT];

    pkt_fifo #(
        .DEPTH (PKT_FIFO_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_pkt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_in_valid),
        .i_pop   (w_pop),
        .i_data  (bus.in_pkt),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // free <= slack  <=>  occupancy >= depth - slack
    assign w_stall   = (w_fifo_count >= CNT_W'(PKT_FIFO_DEPTH - STALL_SLACK));
    assign bus.stall = w_stall;

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [FLIT_W-1:0] r_link_data;
    logic [FLIT_W-1:0] w_data_nxt;
    logic              r_link_valid;
    logic              w_valid_nxt;
    logic              r_link_head;
    logic              w_head_nxt;
    logic              r_link_tail;
    logic              w_tail_nxt;
    logic [CRD_W-1:0]  r_credit_cnt;
    logic              w_can_pop;

    assign w_can_pop = !w_fifo_empty && (r_credit_cnt != '0);

    // The head flit is registered on the same edge that pops the packet.
    // SEND hands back to IDLE together with the tail flit, so a ready packet
    // is popped on the very next edge and its head follows the tail with no gap.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_data_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_head_nxt  = 1'b0;
        w_tail_nxt  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_can_pop) begin
                    w_pop       = 1'b1;
                    w_data_nxt  = w_fifo_data[DATA_W-1 -: FLIT_W];
                    w_shift_nxt = w_fifo_data << FLIT_W;
                    w_valid_nxt = 1'b1;
                    w_head_nxt  = 1'b1;
                    w_idx_nxt   = IDX_W'(1);
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_data_nxt  = r_shift[DATA_W-1 -: FLIT_W];
                w_shift_nxt = r_shift << FLIT_W;
                w_valid_nxt = 1'b1;
                if (r_idx == IDX_W'(NF - 1)) begin
                    w_tail_nxt  = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_link_data  <= '0;
            r_link_valid <= 1'b0;
            r_link_head  <= 1'b0;
            r_link_tail  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_idx        <= w_idx_nxt;
            r_link_data  <= w_data_nxt;
            r_link_valid <= w_valid_nxt;
            r_link_head  <= w_head_nxt;
            r_link_tail  <= w_tail_nxt;
        end
    end

    assign bus.link_data  = r_link_data;
    assign bus.link_valid = r_link_valid;
    assign bus.link_head  = r_link_head;
    assign bus.link_tail  = r_link_tail;

    // ------------------------------------------------------------------
    // Credits and error flags
    // ------------------------------------------------------------------
    // A return at full credit is only harmless if a pop consumes one in the
    // same cycle; otherwise it is a protocol error and is not counted.
    logic w_ret_ok;
    logic w_ret_err;

    assign w_ret_err = bus.credit_ret && (r_credit_cnt == CRD_W'(CREDITS)) && !w_pop;
    assign w_ret_ok  = bus.credit_ret && !w_ret_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit_cnt   <= CRD_W'(CREDITS);
            o_err_overflow <= 1'b0;
            o_err_credit   <= 1'b0;
        end else begin
            case ({w_pop, w_ret_ok})
                2'b10:   r_credit_cnt <= r_credit_cnt - CRD_W'(1);
                2'b01:   r_credit_cnt <= r_credit_cnt + CRD_W'(1);
                default: r_credit_cnt <= r_credit_cnt;
            endcase
            if (w_in_valid && w_fifo_full && !w_pop) begin
                o_err_overflow <= 1'b1;
            end
            if (w_ret_err) begin
                o_err_credit <= 1'b1;
            end
        end
    end

`ifdef LINK_STATS_EN
    // ------------------------------------------------------------------
    // Statistics (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] r_pkt_count;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_tail_nxt) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign o_pkt_count    = r_pkt_count;
    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule : link_tx_serializer

`default_nettype wire

// File: tb/tb_link_tx_serializer.sv
// ============================================================================
// Module      : tb_link_tx_serializer
// Description : Directed self-checking bench for link_tx_serializer.
//               Inputs change and outputs are sampled on the falling edge.
//               Statistics checks are compiled only with LINK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_link_tx_serializer;
    import md_noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err_ovf;
    logic        err_crd;
`ifdef LINK_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] stall_cycles;
`endif

    int n_vec = 0;
    int n_bad = 0;

    link_tx_serializer_if bus ();

    link_tx_serializer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .o_err_overflow (err_ovf),
        .o_err_credit   (err_crd)
`ifdef LINK_STATS_EN
       ,.o_pkt_count    (pkt_count)
       ,.o_stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Packet k: flit i carries k*16+i in its low bits; flit 0 also holds the valid bit.
    function automatic logic [DATA_W-1:0] mk_pkt(input int k);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int i = 0; i < NF; i++) begin
            p[DATA_W-1-FLIT_W*i -: FLIT_W] = 64'(k * 16 + i);
        end
        p[VALID_BIT] = 1'b1;
        return p;
    endfunction

    function automatic logic [FLIT_W-1:0] exp_flit(input int k, input int i);
        logic [FLIT_W-1:0] f;
        f = 64'(k * 16 + i);
        if (i == 0) f[FLIT_W-1] = 1'b1;
        return f;
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.in_pkt     = '0;
        bus.credit_ret = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Checks the next four flits of packet k, starting at the current sample.
    task automatic chk_pkt(input string nm, input int k);
        for (int j = 0; j < NF; j++) begin
            n_vec++;
            if (bus.link_valid !== 1'b1 || bus.link_data !== exp_flit(k, j) ||
                bus.link_head !== (j == 0) || bus.link_tail !== (j == NF - 1)) begin
                n_bad++;
                $display("FAIL %s pkt%0d flit%0d: got v=%b h=%b t=%b d=%h, want v=1 h=%b t=%b d=%h",
                         nm, k, j, bus.link_valid, bus.link_head, bus.link_tail, bus.link_data,
                         (j == 0), (j == NF - 1), exp_flit(k, j));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (bus.link_valid !== 1'b0 || bus.link_head !== 1'b0 || bus.link_tail !== 1'b0 ||
            bus.link_data !== '0 || bus.stall !== 1'b0 || err_ovf !== 1'b0 || err_crd !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b h=%b t=%b d=%h st=%b eo=%b ec=%b, want all 0",
                     bus.link_valid, bus.link_head, bus.link_tail, bus.link_data, bus.stall, err_ovf, err_crd);
        end
        n_vec++;
        if (dut.r_credit_cnt !== 3'd4 || dut.w_fifo_count !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_state: got credit=%0d fifo=%0d, want 4 0", dut.r_credit_cnt, dut.w_fifo_count);
        end
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] p;
        logic [FLIT_W-1:0] e [4];
        e[0] = 64'h8000_0000_0000_0000;
        e[1] = 64'h0;
        e[2] = 64'h0;
        e[3] = 64'h0000_0000_0000_00A5;
        do_reset();
        p = '0;
        p[VALID_BIT] = 1'b1;
        p[7:0] = 8'hA5;
        bus.in_pkt = p;
        @(negedge clk);
        bus.in_pkt = '0;
        n_vec++;
        if (bus.link_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_latency: got valid=%b one cycle after write, want 0", bus.link_valid);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_vec++;
            if (bus.link_valid !== 1'b1 || bus.link_data !== e[j] ||
                bus.link_head !== (j == 0) || bus.link_tail !== (j == 3)) begin
                n_bad++;
                $display("FAIL single_flit%0d: got v=%b h=%b t=%b d=%h, want v=1 h=%b t=%b d=%h",
                         j, bus.link_valid, bus.link_head, bus.link_tail, bus.link_data, (j == 0), (j == 3), e[j]);
            end
        end
        n_vec++;
        if (dut.r_credit_cnt !== 3'd3) begin
            n_bad++;
            $display("FAIL single_credit: got %0d, want 3", dut.r_credit_cnt);
        end
        @(negedge clk);
        n_vec++;
        if (bus.link_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_idle: got valid=%b after tail, want 0", bus.link_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 22; c++) begin
            if (c >= 2 && c < 18) begin
                n_vec++;
                if (bus.link_valid !== 1'b1 || bus.link_data !== exp_flit((c - 2) / 4 + 1, (c - 2) % 4) ||
                    bus.link_head !== ((c - 2) % 4 == 0) || bus.link_tail !== ((c - 2) % 4 == 3)) begin
                    n_bad++;
                    $display("FAIL b2b_cycle%0d: got v=%b h=%b t=%b d=%h, want v=1 d=%h",
                             c, bus.link_valid, bus.link_head, bus.link_tail, bus.link_data,
                             exp_flit((c - 2) / 4 + 1, (c - 2) % 4));
                end
            end else begin
                n_vec++;
                if (bus.link_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_cycle%0d: got valid=%b, want 0", c, bus.link_valid);
                end
            end
            bus.in_pkt = (c < 6) ? mk_pkt(c + 1) : '0;
            @(negedge clk);
        end
        n_vec++;
        if (dut.w_fifo_count !== 4'd2 || dut.r_credit_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL b2b_buffered: got fifo=%0d credit=%0d, want 2 0", dut.w_fifo_count, dut.r_credit_cnt);
        end
        bus.credit_ret = 1'b1;
        @(negedge clk);
        bus.credit_ret = 1'b0;
        n_vec++;
        if (bus.link_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ret_latency: got valid=%b, want 0", bus.link_valid);
        end
        @(negedge clk);
        chk_pkt("b2b_release", 5);
        n_vec++;
        if (bus.link_valid !== 1'b0 || dut.w_fifo_count !== 4'd1) begin
            n_bad++;
            $display("FAIL b2b_after5: got valid=%b fifo=%0d, want 0 1", bus.link_valid, dut.w_fifo_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.in_pkt = mk_pkt(11 + k);
            @(negedge clk);
        end
        bus.in_pkt = '0;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            bus.in_pkt = mk_pkt(20 + k);
            @(negedge clk);
            n_vec++;
            if (bus.stall !== (k >= 5) || dut.w_fifo_count !== 4'(k)) begin
                n_bad++;
                $display("FAIL fill_occ%0d: got stall=%b fifo=%0d, want stall=%b fifo=%0d",
                         k, bus.stall, dut.w_fifo_count, (k >= 5), k);
            end
        end
        n_vec++;
        if (err_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow_pre: got err_overflow=%b, want 0", err_ovf);
        end
        bus.in_pkt = mk_pkt(99);
        @(negedge clk);
        bus.in_pkt = '0;
        n_vec++;
        if (err_ovf !== 1'b1 || dut.w_fifo_count !== 4'd8 || bus.stall !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_drop: got eo=%b fifo=%0d stall=%b, want 1 8 1", err_ovf, dut.w_fifo_count, bus.stall);
        end
        bus.credit_ret = 1'b1;
        @(negedge clk);
        bus.credit_ret = 1'b0;
        @(negedge clk);
        chk_pkt("overflow_intact", 21);
        n_vec++;
        if (dut.w_fifo_count !== 4'd7 || err_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_after: got fifo=%0d eo=%b, want 7 1", dut.w_fifo_count, err_ovf);
        end
    endtask

    task automatic test_credit_edge();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.in_pkt = mk_pkt(30 + k);
            @(negedge clk);
        end
        bus.in_pkt = '0;
        repeat (16) @(negedge clk);
        n_vec++;
        if (dut.r_credit_cnt !== 3'd1) begin
            n_bad++;
            $display("FAIL credit_setup: got %0d, want 1", dut.r_credit_cnt);
        end
        bus.in_pkt = mk_pkt(40);
        @(negedge clk);
        bus.in_pkt = '0;
        bus.credit_ret = 1'b1;
        @(negedge clk);
        bus.credit_ret = 1'b0;
        n_vec++;
        if (dut.r_credit_cnt !== 3'd1 || bus.link_valid !== 1'b1 || bus.link_head !== 1'b1 ||
            bus.link_data !== exp_flit(40, 0)) begin
            n_bad++;
            $display("FAIL credit_pop_ret: got credit=%0d v=%b h=%b d=%h, want 1 1 1 %h",
                     dut.r_credit_cnt, bus.link_valid, bus.link_head, bus.link_data, exp_flit(40, 0));
        end
        repeat (5) @(negedge clk);
        do_reset();
        n_vec++;
        if (err_crd !== 1'b0) begin
            n_bad++;
            $display("FAIL credit_err_pre: got %b, want 0", err_crd);
        end
        bus.credit_ret = 1'b1;
        @(negedge clk);
        bus.credit_ret = 1'b0;
        n_vec++;
        if (err_crd !== 1'b1 || dut.r_credit_cnt !== 3'd4) begin
            n_bad++;
            $display("FAIL credit_err: got err=%b credit=%0d, want 1 4", err_crd, dut.r_credit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.in_pkt = mk_pkt(50);
        @(negedge clk);
        bus.in_pkt = mk_pkt(51);
        @(negedge clk);
        bus.in_pkt = '0;
        @(negedge clk);
        n_vec++;
        if (bus.link_valid !== 1'b1 || bus.link_data !== exp_flit(50, 1) || dut.w_fifo_count !== 4'd1) begin
            n_bad++;
            $display("FAIL midreset_pre: got v=%b d=%h fifo=%0d, want 1 %h 1",
                     bus.link_valid, bus.link_data, dut.w_fifo_count, exp_flit(50, 1));
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.link_valid !== 1'b0 || dut.w_fifo_count !== 4'd0 || dut.r_credit_cnt !== 3'd4) begin
            n_bad++;
            $display("FAIL midreset_async: got v=%b fifo=%0d credit=%0d, want 0 0 4",
                     bus.link_valid, dut.w_fifo_count, dut.r_credit_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.link_valid !== 1'b0 || dut.w_fifo_count !== 4'd0) begin
            n_bad++;
            $display("FAIL midreset_after: got v=%b fifo=%0d, want 0 0", bus.link_valid, dut.w_fifo_count);
        end
    endtask

`ifdef LINK_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            bus.in_pkt = mk_pkt(60 + k);
            @(negedge clk);
            bus.in_pkt = '0;
            repeat (5) @(negedge clk);
            bus.credit_ret = 1'b1;
            @(negedge clk);
            bus.credit_ret = 1'b0;
        end
        n_vec++;
        if (pkt_count !== 32'd10 || stall_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL stats_pkts: got pkt=%0d stall=%0d, want 10 0", pkt_count, stall_cycles);
        end
        for (int k = 0; k < 4; k++) begin
            bus.in_pkt = mk_pkt(80 + k);
            @(negedge clk);
        end
        bus.in_pkt = '0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            bus.in_pkt = mk_pkt(90 + k);
            @(negedge clk);
        end
        bus.in_pkt = '0;
        repeat (7) @(negedge clk);
        n_vec++;
        if (stall_cycles !== 32'd7 || pkt_count !== 32'd14) begin
            n_bad++;
            $display("FAIL stats_stall: got stall=%0d pkt=%0d, want 7 14", stall_cycles, pkt_count);
        end
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        bus.in_pkt     = '0;
        bus.credit_ret = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_credit_edge();
        test_reset_mid();
`ifdef LINK_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_link_tx_serializer

`default_nettype wire
